tx_rr_arbiter: RTL and testbench
================================

# tx_rr_arbiter

Round-robin arbiter that shares the calculator's single serial transmitter among up to N_REQ result sources, such as the RW flow controller, the status reporter and the error reporter. It latches the winning requester's data word and launches the transmitter with a one-cycle start pulse. It then holds the grant until the transmitter reports completion, or until a watchdog timeout expires. Only then does it rotate priority to the next requester.

## Interface
- N_REQ, default 4: number of requesters; minimum 2.
- DATA_W, default 8: width of the transmitted word.
- TIMEOUT_CYC, default 255: maximum number of SEND cycles before the transfer is aborted; minimum 2.
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-high; clears all state and outputs immediately.
- Req  input  N_REQ  level request, one bit per requester.
- Data  input  N_REQ*DATA_W  requester k's word occupies bits [k*DATA_W +: DATA_W].
- TxDone  input  1  transmitter completion; sampled only in SEND.
- Grant  output  N_REQ  one-hot grant; all zero when no transfer is active.
- GrantId  output  $clog2(N_REQ)  index of the granted requester; 0 when idle.
- TxData  output  DATA_W  latched word from the granted requester.
- TxStart  output  1  one-cycle pulse that launches the transmitter.
- Ack  output  N_REQ  one-cycle pulse to requester k when its transfer completes.
- Timeout  output  1  one-cycle pulse when a transfer is aborted.
- Busy  output  1  high from grant until the end of RELEASE.

## Operation
- States: IDLE, SEND, RELEASE. The reset state is IDLE.
- Reset values: Grant=0, GrantId=0, TxData=0, TxStart=0, Ack=0, Timeout=0, Busy=0. The priority pointer Ptr and the watchdog counter Cnt are also reset to 0.
- IDLE, when any Req bit is set:
  - Select k, the first set bit searching circularly from Ptr upward: Ptr, Ptr+1, …, N_REQ-1, 0, ….
  - At the same edge: Grant[k]=1, GrantId=k, TxData=Data[k], TxStart=1, Busy=1, Cnt=0, go to SEND.
- IDLE with Req all zero: stay in IDLE; all outputs stay at their reset values.
- SEND:
  - TxStart is forced to 0 after its first cycle.
  - Cnt increments every cycle in which TxDone is low.
- SEND, TxDone high (normal completion):
  - Grant=0, Ack[k]=1 for one cycle.
  - Ptr = (k+1) mod N_REQ.
  - Go to RELEASE.
- SEND, TxDone low and Cnt == TIMEOUT_CYC-1 (abort):
  - Grant=0, Timeout=1 for one cycle, Ack stays 0.
  - Ptr = (k+1) mod N_REQ.
  - Go to RELEASE.
- If TxDone and the timeout condition occur in the same cycle, TxDone wins: Ack pulses and Timeout does not.
- RELEASE: always lasts one cycle. Busy=0 at its exit edge; return to IDLE. This gap gives the requester time to drop Req after its Ack.
- Cnt width is $clog2(TIMEOUT_CYC); it never wraps because the abort fires first.
- Boundary behaviour:
  - Req[k] dropping while k is granted is ignored; the transfer completes with the latched TxData.
  - Changes on Data during SEND do not affect TxData.
  - TxDone in IDLE or RELEASE is ignored and produces no pulses.
  - A requester that holds Req continuously is served again only after every other active requester has had one turn.
  - Reset asserted mid-transfer clears all outputs immediately with no Ack and no Timeout. The first grant after reset starts its search from requester 0.

## Timing
- Grant latency: Req high before edge E0 while in IDLE gives Grant, TxStart, TxData and Busy valid after E0. TxStart falls after E0+1.
- Completion: TxDone sampled at edge E1 gives Grant low and the Ack pulse after E1, and Busy low after E1+1. The earliest next Grant is after E1+2.
- Timeout: with no TxDone, Timeout pulses after edge E0+TIMEOUT_CYC.
- All outputs are registered, with no combinational paths from inputs to outputs.

## Test plan
1. Single requester: N_REQ=4, Req=0010, Data[1]=0xA5, TxDone pulse 5 cycles after grant.
   - Grant=0010, GrantId=1, TxData=0xA5 and a one-cycle TxStart after the first edge.
   - Ack=0010 for one cycle; Busy low one cycle later.
2. Fairness: Req=1111 held continuously, TxDone returned 3 cycles after each TxStart.
   - Grant sequence is 0, 1, 2, 3, 0.
   - Exactly 2 idle cycles between each TxDone and the next Grant.
3. Timeout: TIMEOUT_CYC=10, Req=0001, TxDone never asserted.
   - Timeout pulses exactly 10 edges after the grant, with Ack=0.
   - Ptr then points to 1: with Req=0011, the next grant goes to requester 1.
4. Simultaneous events, TIMEOUT_CYC=10:
   - TxDone asserted in the cycle where Cnt==9 gives an Ack pulse and no Timeout.
   - TxDone high during IDLE produces no Ack.
5. Reset mid-transfer: assert Reset asynchronously 2 cycles after the grant to requester 2.
   - Grant, Busy and TxStart go to 0 immediately.
   - After release, with Req=1100, the grant goes to requester 2 (search from Ptr=0).
6. Request drop and data stability: Req[0] and Data[0] change during SEND.
   - TxData holds its original value.
   - Ack[0] still pulses when TxDone arrives.

Source files
------------

// File: rtl/tx_rr_arbiter.sv
// Round-robin arbiter sharing one serial transmitter among N_REQ result sources.
// The winner's word is latched and launched with a start pulse; the grant holds until TxDone or a watchdog abort.
module tx_rr_arbiter #(
    parameter int N_REQ       = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [N_REQ-1:0]          Req,
    input  logic [N_REQ*DATA_W-1:0]   Data,
    input  logic                      TxDone,
    output logic [N_REQ-1:0]          Grant,
    output logic [$clog2(N_REQ)-1:0]  GrantId,
    output logic [DATA_W-1:0]         TxData,
    output logic                      TxStart,
    output logic [N_REQ-1:0]          Ack,
    output logic                      Timeout,
    output logic                      Busy
);

    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC);
    localparam logic [ID_W:0]    N_REQ_EXT = (ID_W + 1)'(N_REQ);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_RELEASE
    } state_t;

    state_t            state_q;
    logic [ID_W-1:0]   ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [N_REQ-1:0]  grant_q;
    logic [ID_W-1:0]   grant_id_q;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_start_q;
    logic [N_REQ-1:0]  ack_q;
    logic              timeout_q;
    logic              busy_q;

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [ID_W-1:0]    sel_off;
    logic [ID_W:0]      sel_sum;
    logic               sel_valid_d;
    logic [ID_W-1:0]    sel_id_d;
    logic [N_REQ-1:0]   sel_onehot_d;
    logic [DATA_W-1:0]  sel_data_d;
    logic [ID_W:0]      ptr_inc;
    logic [ID_W-1:0]    ptr_nxt_d;

    // Rotate the request vector so bit 0 is the requester at Ptr; the lowest set bit is the winner.
    assign req_dbl = {Req, Req} >> ptr_q;
    assign req_rot = req_dbl[N_REQ-1:0];

    // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        sel_valid_d = 1'b0;
        sel_off     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                sel_valid_d = 1'b1;
                sel_off     = ID_W'(i);
            end
        end
    end

    assign sel_sum  = {1'b0, ptr_q} + {1'b0, sel_off};
    assign sel_id_d = (sel_sum >= N_REQ_EXT) ? ID_W'(sel_sum - N_REQ_EXT) : sel_sum[ID_W-1:0];

    always_comb begin
        sel_onehot_d = '0;
        sel_data_d   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_id_d == ID_W'(i)) begin
                sel_onehot_d[i] = 1'b1;
                sel_data_d      = Data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_inc   = {1'b0, grant_id_q} + (ID_W + 1)'(1);
    assign ptr_nxt_d = (ptr_inc == N_REQ_EXT) ? '0 : ptr_inc[ID_W-1:0];

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            grant_q    <= '0;
            grant_id_q <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            ack_q      <= '0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            ack_q      <= '0;
            timeout_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sel_valid_d) begin
                        grant_q    <= sel_onehot_d;
                        grant_id_q <= sel_id_d;
                        tx_data_q  <= sel_data_d;
                        tx_start_q <= 1'b1;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Completion takes precedence over an abort in the same cycle.
                    if (TxDone) begin
                        ack_q      <= grant_q;
                        grant_q    <= '0;
                        grant_id_q <= '0;
                        ptr_q      <= ptr_nxt_d;
                        state_q    <= ST_RELEASE;
                    end else if (cnt_q == CNT_LAST) begin
                        timeout_q  <= 1'b1;
                        grant_q    <= '0;
                        grant_id_q <= '0;
                        ptr_q      <= ptr_nxt_d;
                        state_q    <= ST_RELEASE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Grant   = grant_q;
    assign GrantId = grant_id_q;
    assign TxData  = tx_data_q;
    assign TxStart = tx_start_q;
    assign Ack     = ack_q;
    assign Timeout = timeout_q;
    assign Busy    = busy_q;

endmodule

// File: tb/tb_tx_rr_arbiter.sv
// Bench for tx_rr_arbiter: table of transfers with a start/end scoreboard, plus hand-written corner sequences.
module tb_tx_rr_arbiter;

    localparam int N_REQ       = 4;
    localparam int DATA_W      = 8;
    localparam int TIMEOUT_CYC = 10;

    logic        Clk;
    logic        Reset;
    logic [3:0]  Req;
    logic [31:0] Data;
    logic        TxDone;
    logic [3:0]  Grant;
    logic [1:0]  GrantId;
    logic [7:0]  TxData;
    logic        TxStart;
    logic [3:0]  Ack;
    logic        Timeout;
    logic        Busy;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          done_dly;   // edges after the grant edge at which TxDone is sampled
        logic [1:0]  exp_id;
        bit          exp_to;     // 1: TxDone never comes, abort expected
    } vec_t;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } start_exp_t;

    typedef struct {
        logic [3:0] ack;
        logic       to;
    } end_exp_t;

    start_exp_t start_q[$];
    end_exp_t   end_q[$];
    vec_t       vecs[13];
    int         n_cmp = 0;
    int         n_err = 0;

    tx_rr_arbiter #(
        .N_REQ(N_REQ),
        .DATA_W(DATA_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .Req(Req),
        .Data(Data),
        .TxDone(TxDone),
        .Grant(Grant),
        .GrantId(GrantId),
        .TxData(TxData),
        .TxStart(TxStart),
        .Ack(Ack),
        .Timeout(Timeout),
        .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: output event with nothing expected", name);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard side: pop expectations when the DUT launches or ends a transfer.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (TxStart) begin
                if (start_q.size() == 0) begin
                    fail_evt("sb start");
                end else begin
                    start_exp_t s;
                    s = start_q.pop_front();
                    check("sb GrantId", 32'(GrantId), 32'(s.id));
                    check("sb Grant", 32'(Grant), 32'(4'b0001 << s.id));
                    check("sb TxData", 32'(TxData), 32'(s.data));
                end
            end
            if (Ack != 4'b0000 || Timeout) begin
                if (end_q.size() == 0) begin
                    fail_evt("sb end");
                end else begin
                    end_exp_t e;
                    e = end_q.pop_front();
                    check("sb Ack", 32'(Ack), 32'(e.ack));
                    check("sb Timeout", 32'(Timeout), 32'(e.to));
                end
            end
        end
    end

    task automatic do_txn(input vec_t v);
        logic [3:0] oh;
        start_exp_t s;
        end_exp_t   e;
        oh     = 4'b0001 << v.exp_id;
        s.id   = v.exp_id;
        s.data = v.data[int'(v.exp_id)*8 +: 8];
        e.ack  = v.exp_to ? 4'b0000 : oh;
        e.to   = v.exp_to;
        start_q.push_back(s);
        end_q.push_back(e);
        Req  = v.req;
        Data = v.data;
        tick();
        check("grant", 32'(Grant), 32'(oh));
        check("busy at grant", 32'(Busy), 32'd1);
        check("txstart at grant", 32'(TxStart), 32'd1);
        if (v.exp_to) begin
            for (int c = 1; c < TIMEOUT_CYC; c++) begin
                tick();
                if (c == 1) check("txstart falls", 32'(TxStart), 32'd0);
            end
            check("no early timeout", 32'(Timeout), 32'd0);
            tick();
            check("timeout pulse", 32'(Timeout), 32'd1);
            check("no ack on timeout", 32'(Ack), 32'd0);
            check("grant cleared on timeout", 32'(Grant), 32'd0);
        end else begin
            for (int c = 1; c < v.done_dly; c++) begin
                tick();
                if (c == 1) check("txstart falls", 32'(TxStart), 32'd0);
            end
            TxDone = 1'b1;
            tick();
            TxDone = 1'b0;
            check("ack pulse", 32'(Ack), 32'(oh));
            check("no timeout with done", 32'(Timeout), 32'd0);
            check("grant cleared on done", 32'(Grant), 32'd0);
            check("busy in release", 32'(Busy), 32'd1);
        end
        tick();
        check("busy low after release", 32'(Busy), 32'd0);
        check("ack one cycle", 32'(Ack), 32'd0);
        check("timeout one cycle", 32'(Timeout), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Pointer evolution from reset: each expected id is the first Req bit at or after Ptr.
        vecs[0]  = '{4'b1111, 32'h44332211, 3,  2'd0, 1'b0};
        vecs[1]  = '{4'b1111, 32'h44332211, 3,  2'd1, 1'b0};
        vecs[2]  = '{4'b1111, 32'h44332211, 3,  2'd2, 1'b0};
        vecs[3]  = '{4'b1111, 32'h44332211, 3,  2'd3, 1'b0};
        vecs[4]  = '{4'b1111, 32'h44332211, 3,  2'd0, 1'b0};
        vecs[5]  = '{4'b0010, 32'h0000A500, 5,  2'd1, 1'b0};
        vecs[6]  = '{4'b0001, 32'h000000E7, 0,  2'd0, 1'b1};
        vecs[7]  = '{4'b0011, 32'h00005AC3, 2,  2'd1, 1'b0};
        vecs[8]  = '{4'b0100, 32'h007E0000, 10, 2'd2, 1'b0};
        vecs[9]  = '{4'b1001, 32'hF000000F, 1,  2'd3, 1'b0};
        vecs[10] = '{4'b1001, 32'hF000000F, 4,  2'd0, 1'b0};
        vecs[11] = '{4'b0101, 32'h00C30000, 9,  2'd2, 1'b0};
        vecs[12] = '{4'b0001, 32'h000000BE, 0,  2'd0, 1'b1};

        Reset  = 1'b1;
        Req    = 4'b0000;
        Data   = 32'h0;
        TxDone = 1'b0;
        tick();
        tick();
        check("reset Grant", 32'(Grant), 32'd0);
        check("reset GrantId", 32'(GrantId), 32'd0);
        check("reset TxData", 32'(TxData), 32'd0);
        check("reset TxStart", 32'(TxStart), 32'd0);
        check("reset Ack", 32'(Ack), 32'd0);
        check("reset Timeout", 32'(Timeout), 32'd0);
        check("reset Busy", 32'(Busy), 32'd0);
        Reset = 1'b0;
        tick();
        check("idle no grant", 32'(Grant), 32'd0);

        for (int i = 0; i < 13; i++) begin
            do_txn(vecs[i]);
        end

        // TxDone while idle must not produce any pulse.
        Req    = 4'b0000;
        TxDone = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("idle txdone ack", 32'(Ack), 32'd0);
            check("idle txdone timeout", 32'(Timeout), 32'd0);
            check("idle txdone busy", 32'(Busy), 32'd0);
        end
        TxDone = 1'b0;
        tick();

        // Request drop and data change during SEND; Ptr is 1 so requester 0 wins.
        start_q.push_back('{2'd0, 8'h3C});
        end_q.push_back('{4'b0001, 1'b0});
        Req  = 4'b0001;
        Data = 32'h0000003C;
        tick();
        check("drop grant", 32'(Grant), 32'h1);
        Req  = 4'b0000;
        Data = 32'hFFFFFFFF;
        tick();
        check("drop txdata hold 1", 32'(TxData), 32'h3C);
        tick();
        check("drop txdata hold 2", 32'(TxData), 32'h3C);
        check("drop grant held", 32'(Grant), 32'h1);
        TxDone = 1'b1;
        tick();
        check("drop ack", 32'(Ack), 32'h1);
        tick();
        TxDone = 1'b0;
        check("release txdone ignored", 32'(Ack), 32'd0);
        check("release exit busy", 32'(Busy), 32'd0);

        // Move Ptr to 3 so the post-reset grant only goes to 2 if Ptr was cleared.
        do_txn('{4'b0100, 32'h00110000, 2, 2'd2, 1'b0});

        start_q.push_back('{2'd2, 8'h99});
        Req  = 4'b0100;
        Data = 32'h00990000;
        tick();
        check("pre-reset grant", 32'(Grant), 32'h4);
        tick();
        tick();
        #2;
        Reset = 1'b1;
        #1;
        check("async reset Grant", 32'(Grant), 32'd0);
        check("async reset Busy", 32'(Busy), 32'd0);
        check("async reset TxStart", 32'(TxStart), 32'd0);
        check("async reset GrantId", 32'(GrantId), 32'd0);
        check("async reset TxData", 32'(TxData), 32'd0);
        tick();
        check("reset no ack", 32'(Ack), 32'd0);
        check("reset no timeout", 32'(Timeout), 32'd0);
        Reset = 1'b0;
        do_txn('{4'b1100, 32'h66550000, 2, 2'd2, 1'b0});

        tick();
        check("start queue drained", 32'(start_q.size()), 32'd0);
        check("end queue drained", 32'(end_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
